// File: rtl/alu_mdu.sv
// alu_mdu: multi-cycle ALU with registered results and iterative signed/unsigned multiply and divide
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             sign,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             over,
    output logic             div0
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [2*WIDTH-1:0] p, p_next, p_neg;
    logic [WIDTH-1:0] m, a_r, sum, diff, alu_y, a_mag, b_mag, lo_fix, hi_fix;
    logic [WIDTH:0] mul_sum, div_sub;
    logic is_div, neg_lo, neg_hi, dz, alu_ov, lt;
    always_comb begin
        sum = a_in + b_in;
        diff = a_in - b_in;
        lt = sign ? ($signed(a_in) < $signed(b_in)) : (a_in < b_in);
        alu_y = '0;
        case (op)
            4'd0: alu_y = sum;
            4'd1: alu_y = diff;
            4'd2: alu_y = a_in & b_in;
            4'd3: alu_y = a_in | b_in;
            4'd4: alu_y = a_in ^ b_in;
            4'd5: alu_y = ~(a_in | b_in);
            4'd6: alu_y = b_in << (WIDTH / 2);
            4'd7: alu_y = {{(WIDTH-1){1'b0}}, lt};
            4'd8: alu_y = b_in << a_in[SHW-1:0];
            4'd9: alu_y = b_in >> a_in[SHW-1:0];
            4'd10: alu_y = $signed(b_in) >>> a_in[SHW-1:0];
            default: alu_y = '0;
        endcase
        alu_ov = sign && ((op == 4'd0 && a_in[WIDTH-1] == b_in[WIDTH-1] && sum[WIDTH-1] != a_in[WIDTH-1]) ||
                          (op == 4'd1 && a_in[WIDTH-1] != b_in[WIDTH-1] && diff[WIDTH-1] != a_in[WIDTH-1]));
        a_mag = (sign && a_in[WIDTH-1]) ? -a_in : a_in;
        b_mag = (sign && b_in[WIDTH-1]) ? -b_in : b_in;
        mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{p[0]}} & m};
        div_sub = p[2*WIDTH-1:WIDTH-1] - {1'b0, m};
        p_next = (state == DIV) ? (div_sub[WIDTH] ? {p[2*WIDTH-2:0], 1'b0} : {div_sub[WIDTH-1:0], p[WIDTH-2:0], 1'b1})
                                : {mul_sum, p[WIDTH-1:1]};
        p_neg = -p;
        lo_fix = neg_lo ? p_neg[WIDTH-1:0] : p[WIDTH-1:0];
        hi_fix = !neg_hi ? p[2*WIDTH-1:WIDTH] : is_div ? -p[2*WIDTH-1:WIDTH] : p_neg[2*WIDTH-1:WIDTH];
    end
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
            result_hi <= '0;
            zero <= 1'b1;
            over <= 1'b0;
            div0 <= 1'b0;
            cnt <= '0;
            p <= '0;
            m <= '0;
            a_r <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dz <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start && (op == 4'd11 || op == 4'd12)) begin
                        state <= (op == 4'd11) ? MUL : DIV;
                        busy <= 1'b1;
                        cnt <= CNT_W'(WIDTH);
                        is_div <= (op == 4'd12);
                        p <= (op == 4'd12) ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                        m <= (op == 4'd12) ? b_mag : a_mag;
                        neg_lo <= sign && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        neg_hi <= (op == 4'd12) ? (sign && a_in[WIDTH-1]) : (sign && (a_in[WIDTH-1] ^ b_in[WIDTH-1]));
                        dz <= (op == 4'd12) && (b_in == '0);
                        a_r <= a_in;
                    end else if (start) begin
                        state <= DONE;
                        done <= 1'b1;
                        result <= alu_y;
                        result_hi <= '0;
                        zero <= (alu_y == '0);
                        over <= alu_ov;
                        div0 <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL, DIV: begin
                    p <= p_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                    result <= dz ? '1 : lo_fix;
                    result_hi <= dz ? a_r : hi_fix;
                    zero <= dz ? 1'b0 : (lo_fix == '0);
                    over <= 1'b0;
                    div0 <= dz;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed and randomized self-checking bench against a longint reference model
module tb_alu_mdu;
    localparam int W = 32;
    logic CLK = 1'b0, Reset = 1'b0, start = 1'b0, sign = 1'b0;
    logic [3:0] op = '0;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic busy, done, zero, over, div0;
    logic [W-1:0] result, result_hi;
    int checks = 0, errors = 0;

    alu_mdu #(.WIDTH(W)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .op(op), .sign(sign),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .result(result),
        .result_hi(result_hi), .zero(zero), .over(over), .div0(div0)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic ov;
        logic dz;
        int lat;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sb, t;
        logic [63:0] u;
        logic [4:0] sh;
        e.res = '0; e.hi = '0; e.ov = 1'b0; e.dz = 1'b0; e.lat = 1;
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        sh = a[4:0];
        case (o)
            4'd0: begin e.res = a + b; t = sa + sb; e.ov = s && (t != longint'($signed(e.res))); end
            4'd1: begin e.res = a - b; t = sa - sb; e.ov = s && (t != longint'($signed(e.res))); end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = ~(a | b);
            4'd6: e.res = b << (W / 2);
            4'd7: e.res = (sa < sb) ? 1 : 0;
            4'd8: e.res = b << sh;
            4'd9: e.res = b >> sh;
            4'd10: e.res = $signed(b) >>> sh;
            4'd11: begin
                u = sa * sb;
                e.res = u[31:0]; e.hi = u[63:32]; e.lat = W + 2;
            end
            4'd12: begin
                e.lat = W + 2;
                if (b == 0) begin
                    e.res = '1; e.hi = a; e.dz = 1'b1;
                end else begin
                    u = sa / sb; e.res = u[31:0];
                    u = sa % sb; e.hi = u[31:0];
                end
            end
            default: e.res = '0;
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [3:0] o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int lat, bc;
        e = model(o, s, a, b);
        @(negedge CLK);
        op = o; sign = s; a_in = a; b_in = b; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0; a_in = $urandom; b_in = $urandom; op = 4'($urandom); sign = 1'($urandom);
        lat = 1; bc = 0;
        while (!done && lat < 200) begin
            if (busy) bc++;
            @(posedge CLK);
            #1;
            lat++;
        end
        check($sformatf("lat op%0d", o), 64'(lat), 64'(e.lat));
        check($sformatf("busy_cycles op%0d", o), 64'(bc), 64'(e.lat - 1));
        check($sformatf("busy_at_done op%0d", o), 64'(busy), 64'(0));
        check($sformatf("result op%0d a=%h b=%h s=%0d", o, a, b, s), 64'(result), 64'(e.res));
        check($sformatf("result_hi op%0d a=%h b=%h s=%0d", o, a, b, s), 64'(result_hi), 64'(e.hi));
        check($sformatf("zero op%0d", o), 64'(zero), 64'(e.res == 0));
        check($sformatf("over op%0d", o), 64'(over), 64'(e.ov));
        check($sformatf("div0 op%0d", o), 64'(div0), 64'(e.dz));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " done"}, 64'(done), 64'(0));
        check({tag, " result"}, 64'(result), 64'(0));
        check({tag, " result_hi"}, 64'(result_hi), 64'(0));
        check({tag, " zero"}, 64'(zero), 64'(1));
        check({tag, " over"}, 64'(over), 64'(0));
        check({tag, " div0"}, 64'(div0), 64'(0));
    endtask

    initial begin
        int dones;
        logic [3:0] ro;
        logic [W-1:0] ra, rb;
        Reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_state("reset");
        @(negedge CLK);
        Reset = 1'b1;
        run_op(4'd0, 1'b1, 32'h7FFFFFFF, 32'h1);
        run_op(4'd0, 1'b0, 32'h7FFFFFFF, 32'h1);
        run_op(4'd1, 1'b1, 32'd5, 32'd5);
        run_op(4'd10, 1'b0, 32'd4, 32'h80000000);
        run_op(4'd7, 1'b0, 32'hFFFFFFFF, 32'd1);
        run_op(4'd7, 1'b1, 32'hFFFFFFFF, 32'd1);
        run_op(4'd1, 1'b1, 32'h80000000, 32'd1);
        run_op(4'd6, 1'b0, 32'd0, 32'h0000ABCD);
        run_op(4'd13, 1'b1, 32'd9, 32'd9);
        run_op(4'd11, 1'b1, -32'sd3, 32'd7);
        run_op(4'd11, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(4'd12, 1'b1, -32'sd7, 32'd2);
        run_op(4'd12, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_op(4'd12, 1'b1, 32'h1234, 32'd0);
        run_op(4'd12, 1'b0, 32'hFFFFFFF0, 32'd7);
        run_op(4'd12, 1'b1, 32'd100, -32'sd7);
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 40));
            run_op(ro, 1'($urandom), ra, rb);
        end
        run_op(4'd0, 1'b0, 32'd1, 32'd2);
        @(negedge CLK);
        op = 4'd11; sign = 1'b1; a_in = 32'd5; b_in = 32'd6; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        op = 4'd0; a_in = 32'd10; b_in = 32'd20; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check("ignored_start busy", 64'(busy), 64'(1));
        check("ignored_start result", 64'(result), 64'(3));
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        check_reset_state("midop_reset");
        @(negedge CLK);
        Reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (done) dones++;
        end
        check("no_done_after_abort", 64'(dones), 64'(0));
        check("idle_after_abort busy", 64'(busy), 64'(0));
        run_op(4'd0, 1'b1, 32'd40, 32'd2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
